// File: rtl/rv_enc_pkg.sv
// Shared types and opcode constants for the RV32I instruction encoder.
// Helpers classify an opcode into its instruction format and test immediate fit.
package rv_enc_pkg;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd6
   } fmt_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_RANGE    = 2'b01,
      ERR_MISALIGN = 2'b10,
      ERR_ILLEGAL  = 2'b11
   } err_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [31:0] MASK_IS = 32'hFFFF_F800;
   localparam logic [31:0] MASK_B  = 32'hFFFF_F000;
   localparam logic [31:0] MASK_J  = 32'hFFF0_0000;

   function automatic fmt_t fmt_of(input logic [6:0] op);
      fmt_t f;
      case (op)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: f = FMT_I;
         OP_STORE:                           f = FMT_S;
         OP_BRANCH:                          f = FMT_B;
         OP_JAL:                             f = FMT_J;
         OP_LUI, OP_AUIPC:                   f = FMT_U;
         OP_REG:                             f = FMT_R;
         default:                            f = FMT_ILL;
      endcase
      return f;
   endfunction

   // The bits under mask must all copy the sign, i.e. be all ones or all zeros.
   function automatic logic sext_ok(input logic [31:0] v, input logic [31:0] mask);
      return ((v & mask) == mask) || ((v & mask) == 32'h0000_0000);
   endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational format decode, field packing and immediate checks.
// Unused fields of a format are simply not placed into the word.
module inst_pack
   import rv_enc_pkg::*;
(
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] inst_word,
   output logic [1:0]  err_code
);

   fmt_t        fmt_s;
   err_t        err_s;
   logic [31:0] word_s;
   logic        range_bad_s;
   logic        misalign_s;

   // Pack the instruction word and flag immediate problems for the decoded format.
   always_comb begin
      fmt_s       = fmt_of(opcode);
      word_s      = 32'h0000_0000;
      range_bad_s = 1'b0;
      misalign_s  = 1'b0;
      case (fmt_s)
         FMT_R: word_s = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            word_s      = {imm[11:0], rs1, funct3, rd, opcode};
            range_bad_s = !sext_ok(imm, MASK_IS);
         end
         FMT_S: begin
            word_s      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            range_bad_s = !sext_ok(imm, MASK_IS);
         end
         FMT_B: begin
            word_s      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            range_bad_s = !sext_ok(imm, MASK_B);
            misalign_s  = imm[0];
         end
         FMT_J: begin
            word_s      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            range_bad_s = !sext_ok(imm, MASK_J);
            misalign_s  = imm[0];
         end
         FMT_U: begin
            word_s     = {imm[31:12], rd, opcode};
            misalign_s = (imm[11:0] != 12'h000);
         end
         default: word_s = 32'h0000_0000;
      endcase

      if (fmt_s == FMT_ILL) begin
         err_s = ERR_ILLEGAL;
      end else if (misalign_s) begin
         err_s = ERR_MISALIGN;
      end else if (range_bad_s) begin
         err_s = ERR_RANGE;
      end else begin
         err_s = ERR_NONE;
      end
   end

   assign inst_word = word_s;
   assign err_code  = err_s;

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: valid/ready handshake around inst_pack with one
// registered output stage, a sticky error flag and an accepted-input counter.
module inst_encoder
   import rv_enc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       opcode,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [31:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      inst_code,
   output logic             out_err,
   output logic [1:0]       err_code,
   output logic             err_sticky,
   input  logic             clr_err,
   output logic [CNT_W-1:0] enc_count
);

   logic [31:0]      pack_word_s;
   logic [1:0]       pack_err_s;
   logic             accept_s;

   logic             out_valid_d, out_valid_q;
   logic [31:0]      inst_code_d, inst_code_q;
   logic             out_err_d, out_err_q;
   logic [1:0]       err_code_d, err_code_q;
   logic             err_sticky_d, err_sticky_q;
   logic [CNT_W-1:0] enc_count_d, enc_count_q;

   inst_pack u_pack (
      .opcode    (opcode),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .funct3    (funct3),
      .funct7    (funct7),
      .imm       (imm),
      .inst_word (pack_word_s),
      .err_code  (pack_err_s)
   );

   // The output slot frees up in the same cycle it drains, giving full throughput.
   assign in_ready = !out_valid_q || out_ready;
   assign accept_s = in_valid && in_ready;

   // Next-state for the output stage, sticky error and counter.
   always_comb begin
      out_valid_d  = out_valid_q;
      inst_code_d  = inst_code_q;
      out_err_d    = out_err_q;
      err_code_d   = err_code_q;
      err_sticky_d = err_sticky_q;
      enc_count_d  = enc_count_q;
      if (accept_s) begin
         out_valid_d = 1'b1;
         inst_code_d = pack_word_s;
         out_err_d   = (pack_err_s != ERR_NONE);
         err_code_d  = pack_err_s;
         enc_count_d = enc_count_q + CNT_W'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      // A new error outranks a simultaneous clear.
      if (accept_s && (pack_err_s != ERR_NONE)) begin
         err_sticky_d = 1'b1;
      end else if (clr_err) begin
         err_sticky_d = 1'b0;
      end else begin
         err_sticky_d = err_sticky_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         inst_code_q  <= 32'h0000_0000;
         out_err_q    <= 1'b0;
         err_code_q   <= 2'b00;
         err_sticky_q <= 1'b0;
         enc_count_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         inst_code_q  <= inst_code_d;
         out_err_q    <= out_err_d;
         err_code_q   <= err_code_d;
         err_sticky_q <= err_sticky_d;
         enc_count_q  <= enc_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign inst_code  = inst_code_q;
   assign out_err    = out_err_q;
   assign err_code   = err_code_q;
   assign err_sticky = err_sticky_q;
   assign enc_count  = enc_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed cases plus randomized traffic
// scored against an arithmetic reference encoder and an immediate decoder.
module tb_inst_encoder;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [6:0]       opcode = 7'h00;
   logic [4:0]       rd = 5'h00;
   logic [4:0]       rs1 = 5'h00;
   logic [4:0]       rs2 = 5'h00;
   logic [2:0]       funct3 = 3'h0;
   logic [6:0]       funct7 = 7'h00;
   logic [31:0]      imm = 32'h0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      inst_code;
   logic             out_err;
   logic [1:0]       err_code;
   logic             err_sticky;
   logic             clr_err = 1'b0;
   logic [CNT_W-1:0] enc_count;

   int pass_cnt = 0;
   int total_cnt = 0;
   int exp_cnt = 0;
   logic model_sticky = 1'b0;

   typedef struct {
      logic [31:0] code;
      logic [1:0]  err;
      logic [31:0] imm;
      int          fmt;
   } exp_t;
   exp_t sb[$];

   inst_encoder #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
      .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
      .inst_code(inst_code), .out_err(out_err), .err_code(err_code),
      .err_sticky(err_sticky), .clr_err(clr_err), .enc_count(enc_count)
   );

   always #5 clk = ~clk;

   // Format ids: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 illegal
   function automatic int fmt_of_op(input logic [6:0] op);
      case (op)
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: return 1;
         7'b0100011: return 2;
         7'b1100011: return 3;
         7'b0110111, 7'b0010111: return 4;
         7'b1101111: return 5;
         7'b0110011: return 0;
         default: return 6;
      endcase
   endfunction

   task automatic model_enc(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] im, output logic [31:0] code,
                            output logic [1:0] err, output int fmt);
      longint sv;
      logic range_bad, mis;
      sv = longint'($signed(im));
      fmt = fmt_of_op(op);
      range_bad = 1'b0;
      mis = 1'b0;
      code = 32'h0;
      case (fmt)
         0: code = (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                   | (32'(d) << 7) | 32'(op);
         1: begin
            code = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
            range_bad = (sv < -2048) || (sv > 2047);
         end
         2: begin
            code = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                   | (32'(f3) << 12) | ((im & 32'h1F) << 7) | 32'(op);
            range_bad = (sv < -2048) || (sv > 2047);
         end
         3: begin
            code = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                   | (32'(s1) << 15) | (32'(f3) << 12) | (((im >> 1) & 32'hF) << 8)
                   | (((im >> 11) & 32'h1) << 7) | 32'(op);
            range_bad = (sv < -4096) || (sv > 4095);
            mis = (im % 2) != 0;
         end
         4: begin
            code = (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
            mis = (im % 4096) != 0;
         end
         5: begin
            code = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                   | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                   | (32'(d) << 7) | 32'(op);
            range_bad = (sv < -1048576) || (sv > 1048575);
            mis = (im % 2) != 0;
         end
         default: code = 32'h0;
      endcase
      if (fmt == 6) err = 2'b11;
      else if (mis) err = 2'b10;
      else if (range_bad) err = 2'b01;
      else err = 2'b00;
   endtask

   // Core-style immediate generator, used for the round-trip property.
   function automatic logic [31:0] imm_gen(input int fmt, input logic [31:0] c);
      case (fmt)
         1: return {{20{c[31]}}, c[31:20]};
         2: return {{20{c[31]}}, c[31:25], c[11:7]};
         3: return {{19{c[31]}}, c[31], c[7], c[30:25], c[11:8], 1'b0};
         5: return {{11{c[31]}}, c[31], c[19:12], c[20], c[30:21], 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
      opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = 7'h00; imm = im;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      total_cnt++;
      if ({out_valid, inst_code, out_err, err_code, err_sticky, enc_count} !== '0)
         $display("FAIL reset_outputs: got v=%b code=%h err=%b ec=%b st=%b cnt=%0d required all 0",
                  out_valid, inst_code, out_err, err_code, err_sticky, enc_count);
      else pass_cnt++;
      step();
      step();
      reset = 1'b0;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
      else pass_cnt++;
   endtask

   task automatic test_directed();
      logic [6:0]  ops[3]  = '{7'b0010011, 7'b0100011, 7'b1100011};
      logic [4:0]  rds[3]  = '{5'd1, 5'd0, 5'd0};
      logic [4:0]  r1s[3]  = '{5'd2, 5'd2, 5'd0};
      logic [4:0]  r2s[3]  = '{5'd0, 5'd5, 5'd0};
      logic [2:0]  f3s[3]  = '{3'b000, 3'b010, 3'b000};
      logic [31:0] imms[3] = '{32'hFFFF_FFFF, 32'h0000_0008, 32'hFFFF_FFFC};
      logic [31:0] gold[3] = '{32'hFFF1_0093, 32'h0051_2423, 32'hFE00_0EE3};
      logic [31:0] mcode;
      logic [1:0]  merr;
      int          mfmt;
      for (int i = 0; i < 3; i++) begin
         drive(ops[i], rds[i], r1s[i], r2s[i], f3s[i], imms[i]);
         model_enc(ops[i], rds[i], r1s[i], r2s[i], f3s[i], 7'h00, imms[i], mcode, merr, mfmt);
         in_valid = 1'b1;
         out_ready = 1'b1;
         step();
         in_valid = 1'b0;
         exp_cnt++;
         total_cnt++;
         if (out_valid !== 1'b1 || inst_code !== gold[i] || out_err !== 1'b0)
            $display("FAIL directed_%0d: got v=%b code=%h err=%b required v=1 code=%h err=0",
                     i, out_valid, inst_code, out_err, gold[i]);
         else pass_cnt++;
         total_cnt++;
         if (mcode !== gold[i] || imm_gen(mfmt, inst_code) !== imms[i])
            $display("FAIL directed_model_%0d: model code=%h roundtrip imm=%h required code=%h imm=%h",
                     i, mcode, imm_gen(mfmt, inst_code), gold[i], imms[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (enc_count !== CNT_W'(exp_cnt))
         $display("FAIL directed_count: got %0d required %0d", enc_count, exp_cnt % 16);
      else pass_cnt++;
      step();
   endtask

   task automatic test_errors();
      drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 32'h0000_0003);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      exp_cnt++;
      total_cnt++;
      if (err_code !== 2'b10 || out_err !== 1'b1 || err_sticky !== 1'b1)
         $display("FAIL err_misalign: got ec=%b err=%b st=%b required ec=10 err=1 st=1",
                  err_code, out_err, err_sticky);
      else pass_cnt++;
      step();
      step();
      total_cnt++;
      if (err_sticky !== 1'b1) $display("FAIL sticky_hold: got %b required 1", err_sticky);
      else pass_cnt++;

      drive(7'b0010011, 5'd3, 5'd4, 5'd0, 3'b000, 32'h0000_0800);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      exp_cnt++;
      total_cnt++;
      if (err_code !== 2'b01 || out_err !== 1'b1 || inst_code !== 32'h8002_0193)
         $display("FAIL err_range: got ec=%b err=%b code=%h required ec=01 err=1 code=80020193",
                  err_code, out_err, inst_code);
      else pass_cnt++;

      drive(7'b0000000, 5'd3, 5'd4, 5'd5, 3'b111, 32'h0000_0010);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      exp_cnt++;
      total_cnt++;
      if (err_code !== 2'b11 || out_err !== 1'b1 || inst_code !== 32'h0)
         $display("FAIL err_illegal: got ec=%b err=%b code=%h required ec=11 err=1 code=0",
                  err_code, out_err, inst_code);
      else pass_cnt++;

      clr_err = 1'b1;
      step();
      total_cnt++;
      if (err_sticky !== 1'b0) $display("FAIL sticky_clear: got %b required 0", err_sticky);
      else pass_cnt++;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      clr_err = 1'b0;
      exp_cnt++;
      total_cnt++;
      if (err_sticky !== 1'b1) $display("FAIL sticky_set_wins: got %b required 1", err_sticky);
      else pass_cnt++;
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      model_sticky = 1'b0;
      total_cnt++;
      if (enc_count !== CNT_W'(exp_cnt))
         $display("FAIL errors_count: got %0d required %0d", enc_count, exp_cnt % 16);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      step();
      drive(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 32'hFFFF_FFFF);
      in_valid = 1'b1;
      out_ready = 1'b0;
      step();
      exp_cnt++;
      drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 32'h0000_0008);
      #1;
      total_cnt++;
      if (in_ready !== 1'b0 || inst_code !== 32'hFFF1_0093)
         $display("FAIL stall_first: got rdy=%b code=%h required rdy=0 code=fff10093", in_ready, inst_code);
      else pass_cnt++;
      step();
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || inst_code !== 32'hFFF1_0093 || out_err !== 1'b0 || err_code !== 2'b00)
         $display("FAIL stall_hold: got v=%b code=%h err=%b ec=%b required v=1 code=fff10093 err=0 ec=00",
                  out_valid, inst_code, out_err, err_code);
      else pass_cnt++;
      out_ready = 1'b1;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL release_ready: got %b required 1", in_ready);
      else pass_cnt++;
      step();
      in_valid = 1'b0;
      exp_cnt++;
      total_cnt++;
      if (out_valid !== 1'b1 || inst_code !== 32'h0051_2423 || enc_count !== CNT_W'(exp_cnt))
         $display("FAIL second_out: got v=%b code=%h cnt=%0d required v=1 code=00512423 cnt=%0d",
                  out_valid, inst_code, enc_count, exp_cnt % 16);
      else pass_cnt++;
      step();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL drain_empty: got %b required 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [6:0]  legal[10] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011};
      logic [31:0] r;
      int          sel;
      logic        rdy;
      exp_t        e;
      for (int cyc = 0; cyc < 500; cyc++) begin
         sel = $urandom_range(0, 10);
         if (sel == 10) begin
            r = $urandom;
            opcode = r[6:0];
         end else opcode = legal[sel];
         r = $urandom;
         rd = r[4:0]; rs1 = r[9:5]; rs2 = r[14:10]; funct3 = r[17:15]; funct7 = r[24:18];
         sel = $urandom_range(0, 3);
         if (sel == 0) imm = 32'($urandom_range(0, 8191)) - 32'd4096;
         else if (sel == 1) imm = $urandom;
         else if (sel == 2) imm = $urandom & 32'hFFFF_F000;
         else imm = (32'($urandom_range(0, 2047)) << 1) - 32'd2048;
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         clr_err = ($urandom_range(0, 15) == 0);
         #1;
         rdy = (sb.size() == 0) || out_ready;
         total_cnt++;
         if (in_ready !== rdy) $display("FAIL rand_in_ready: cyc %0d got %b required %b", cyc, in_ready, rdy);
         else pass_cnt++;
         total_cnt++;
         if (out_valid !== (sb.size() != 0))
            $display("FAIL rand_out_valid: cyc %0d got %b required %b", cyc, out_valid, sb.size() != 0);
         else pass_cnt++;
         if (sb.size() != 0) begin
            e = sb[0];
            total_cnt++;
            if (inst_code !== e.code || err_code !== e.err || out_err !== (e.err != 2'b00))
               $display("FAIL rand_word: cyc %0d got code=%h ec=%b err=%b required code=%h ec=%b",
                        cyc, inst_code, err_code, out_err, e.code, e.err);
            else pass_cnt++;
            if (e.err == 2'b00 && (e.fmt == 1 || e.fmt == 2 || e.fmt == 3 || e.fmt == 5)) begin
               total_cnt++;
               if (imm_gen(e.fmt, inst_code) !== e.imm)
                  $display("FAIL rand_roundtrip: cyc %0d got imm=%h required %h",
                           cyc, imm_gen(e.fmt, inst_code), e.imm);
               else pass_cnt++;
            end
            if (out_ready) void'(sb.pop_front());
         end
         total_cnt++;
         if (err_sticky !== model_sticky || enc_count !== CNT_W'(exp_cnt))
            $display("FAIL rand_state: cyc %0d got st=%b cnt=%0d required st=%b cnt=%0d",
                     cyc, err_sticky, enc_count, model_sticky, exp_cnt % 16);
         else pass_cnt++;
         if (in_valid && rdy) begin
            model_enc(opcode, rd, rs1, rs2, funct3, funct7, imm, e.code, e.err, e.fmt);
            e.imm = imm;
            sb.push_back(e);
            exp_cnt++;
            if (e.err != 2'b00) model_sticky = 1'b1;
            else if (clr_err) model_sticky = 1'b0;
         end else if (clr_err) model_sticky = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      clr_err = 1'b0;
      step();
      sb.delete();
   endtask

   task automatic test_count_wrap();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      exp_cnt = 0;
      model_sticky = 1'b0;
      drive(7'b0110011, 5'd1, 5'd2, 5'd3, 3'b000, 32'h0);
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) step();
      total_cnt++;
      if (enc_count !== 4'd15) $display("FAIL count_15: got %0d required 15", enc_count);
      else pass_cnt++;
      step();
      step();
      in_valid = 1'b0;
      total_cnt++;
      if (enc_count !== 4'd1) $display("FAIL count_wrap: got %0d required 1", enc_count);
      else pass_cnt++;
      step();
   endtask

   task automatic test_async_reset();
      drive(7'b0000000, 5'd1, 5'd1, 5'd1, 3'b000, 32'h0);
      in_valid = 1'b1;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b1 || err_sticky !== 1'b1 || enc_count !== 4'd2)
         $display("FAIL pre_reset: got v=%b st=%b cnt=%0d required v=1 st=1 cnt=2",
                  out_valid, err_sticky, enc_count);
      else pass_cnt++;
      #2;
      reset = 1'b1;
      #1;
      total_cnt++;
      if ({out_valid, inst_code, out_err, err_code, err_sticky, enc_count} !== '0)
         $display("FAIL async_reset: got v=%b code=%h err=%b ec=%b st=%b cnt=%0d required all 0",
                  out_valid, inst_code, out_err, err_code, err_sticky, enc_count);
      else pass_cnt++;
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_errors();
      test_back_to_back();
      test_random();
      test_count_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
